// File: rtl/alarma_pkg.sv
// alarma_pkg: state codes, parameter defaults and counter sizing shared by the alarma_luz blocks.
package alarma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARMING = 2'b01,
        ARMED  = 2'b10,
        ALARM  = 2'b11
    } state_t;

    localparam int DEB_CYCLES_DEF = 3;
    localparam int ARM_DELAY_DEF  = 8;
    localparam int BLINK_DIV_DEF  = 4;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarma_debounce.sv
// alarma_debounce: 2-flop synchronizer, debounce filter when ALARMA_DEBOUNCE_EN is defined, one-cycle press pulse.
// A level already high when reset is released is not reported until it has been seen low.
module alarma_debounce
    import alarma_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic press
);

`ifdef ALARMA_DEBOUNCE_EN
    localparam int DEB_N = DEB_CYCLES;
`else
    localparam int DEB_N = 0 * DEB_CYCLES;
`endif

    logic [1:0] sync;
    logic [1:0] vld;
    logic       lvl;
    logic       prev;
    logic       ok;

    // vld marks when sync[1] carries a real sample rather than its reset value
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync <= '0;
            vld  <= '0;
            prev <= 1'b0;
            ok   <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            vld  <= {vld[0], 1'b1};
            prev <= lvl;
            ok   <= ok | (vld[1] & ~sync[1]);
        end
    end

    generate
        if (DEB_N > 0) begin : g_filt
            localparam int             DW   = cnt_w(DEB_N);
            localparam logic [DW-1:0]  LAST = DW'(DEB_N - 1);
            logic [DW-1:0] cnt;
            logic          deb;
            always_ff @(posedge CLK) begin
                if (!RST) begin
                    cnt <= '0;
                    deb <= 1'b0;
                end else if (sync[1] == deb) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    deb <= sync[1];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            assign lvl = deb;
        end else begin : g_raw
            assign lvl = sync[1];
        end
    endgenerate

    assign press = lvl & ~prev & ok;

endmodule

// File: rtl/alarma_luz.sv
// alarma_luz: push-button armed intrusion alarm driving a steady/blinking light.
// Define ALARMA_DEBOUNCE_EN to filter Button bounce over DEB_CYCLES synchronized samples.
module alarma_luz
    import alarma_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int ARM_DELAY  = ARM_DELAY_DEF,
    parameter int BLINK_DIV  = BLINK_DIV_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Button,
    input  logic       SENSOR,
    output logic       LUZ,
    output logic [1:0] ESTADO
);

    localparam int            AW         = cnt_w(ARM_DELAY);
    localparam int            BW         = cnt_w(BLINK_DIV);
    localparam logic [AW-1:0] ARM_LAST   = AW'(ARM_DELAY - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_t        state, state_n;
    logic [AW-1:0] arm_cnt, arm_cnt_n;
    logic [BW-1:0] blk_cnt, blk_cnt_n;
    logic          luz_n;
    logic          press;
    logic [1:0]    sens;

    alarma_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
        .CLK  (CLK),
        .RST  (RST),
        .din  (Button),
        .press(press)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            arm_cnt <= '0;
            blk_cnt <= '0;
            LUZ     <= 1'b0;
            sens    <= '0;
        end else begin
            state   <= state_n;
            arm_cnt <= arm_cnt_n;
            blk_cnt <= blk_cnt_n;
            LUZ     <= luz_n;
            sens    <= {sens[0], SENSOR};
        end
    end

    // counters default to zero so every state entry starts them cleared
    always_comb begin
        state_n   = state;
        arm_cnt_n = '0;
        blk_cnt_n = '0;
        luz_n     = 1'b0;
        case (state)
            IDLE: begin
                state_n = press ? ARMING : IDLE;
                luz_n   = press;
            end
            ARMING: begin
                state_n   = press ? IDLE : (arm_cnt == ARM_LAST) ? ARMED : ARMING;
                luz_n     = state_n == ARMING;
                arm_cnt_n = (state_n == ARMING) ? arm_cnt + 1'b1 : '0;
            end
            ARMED: begin
                state_n = press ? IDLE : sens[1] ? ALARM : ARMED;
                luz_n   = state_n == ALARM;
            end
            ALARM: begin
                state_n   = press ? IDLE : ALARM;
                blk_cnt_n = (press || blk_cnt == BLINK_LAST) ? '0 : blk_cnt + 1'b1;
                luz_n     = !press && (LUZ ^ (blk_cnt == BLINK_LAST));
            end
            default: state_n = IDLE;
        endcase
    end

    assign ESTADO = state;

endmodule

// File: tb/tb_alarma_luz.sv
// tb_alarma_luz: directed scenarios plus random stimulus, checked every cycle against a sample-history model.
module tb_alarma_luz;

    localparam int DEB  = 3;
    localparam int ARM  = 8;
    localparam int BLK  = 4;
    localparam int MAXN = 8192;
`ifdef ALARMA_DEBOUNCE_EN
    localparam int P      = 2 + DEB;
    localparam int DB     = DEB;
    localparam bit DEB_ON = 1'b1;
`else
    localparam int P      = 2;
    localparam int DB     = 1;
    localparam bit DEB_ON = 1'b0;
`endif

    logic       CLK    = 1'b0;
    logic       RST    = 1'b0;
    logic       Button = 1'b1;
    logic       SENSOR = 1'b1;
    logic       LUZ;
    logic [1:0] ESTADO;

    int n_asrt = 0;
    int n_fail = 0;

    alarma_luz #(.DEB_CYCLES(DEB), .ARM_DELAY(ARM), .BLINK_DIV(BLK)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Button(Button),
        .SENSOR(SENSOR),
        .LUZ   (LUZ),
        .ESTADO(ESTADO)
    );

    always #5 CLK = ~CLK;

    // model: input samples indexed by edge number since reset release
    bit bh[MAXN];
    bit sh[MAXN];
    bit lv[MAXN];
    int n = 0, first_low = -1, ent = 0, m_st = 0;
    bit m_luz = 1'b0, model_ok = 1'b0, mp, ms;

    function automatic bit syn(input int j);
        return (j >= 2) ? bh[j-2] : 1'b0;
    endfunction

    function automatic bit level_at(input int k);
        bit all1 = 1'b1;
        bit all0 = 1'b1;
        for (int j = k - DEB + 1; j <= k; j++) begin
            all1 &= syn(j);
            all0 &= ~syn(j);
        end
        return all1 ? 1'b1 : all0 ? 1'b0 : (k > 0 ? lv[k-1] : 1'b0);
    endfunction

    function automatic bit press_at(input int k);
`ifdef ALARMA_DEBOUNCE_EN
        return k >= 1 && lv[k-1] && !(k >= 2 && lv[k-2]) && first_low >= 0 && first_low <= k - 3;
`else
        return k >= 3 && bh[k-2] && !bh[k-3];
`endif
    endfunction

    always @(posedge CLK) begin
        if (!RST) begin
            n = 0; first_low = -1; m_st = 0; ent = 0; m_luz = 1'b0;
        end else if (n < MAXN) begin
            bh[n] = Button;
            sh[n] = SENSOR;
            if (!Button && first_low < 0) first_low = n;
            lv[n] = level_at(n);
            mp = press_at(n);
            ms = n >= 2 && sh[n-2];
            case (m_st)
                0: if (mp) begin m_st = 1; ent = n; end
                1: if (mp) m_st = 0; else if (n - ent == ARM) begin m_st = 2; ent = n; end
                2: if (mp) m_st = 0; else if (ms) begin m_st = 3; ent = n; end
                default: if (mp) m_st = 0;
            endcase
            m_luz = m_st == 1 || (m_st == 3 && ((n - ent) / BLK) % 2 == 0);
            n++;
        end
        model_ok = 1'b1;
    end

    always @(negedge CLK) begin
        if (model_ok) begin
            n_asrt++;
            if (ESTADO !== 2'(m_st) || LUZ !== m_luz) begin
                n_fail++;
                $display("FAIL model t=%0t ESTADO=%0d LUZ=%0b expected ESTADO=%0d LUZ=%0b",
                         $time, ESTADO, LUZ, m_st, m_luz);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge CLK);
    endtask

    logic [11:0] pat;
    logic [1:0]  last;
    int          chg, seen, hold;

    initial begin
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("reset_estado", 32'(ESTADO), 0);
            chk("reset_luz", 32'(LUZ), 0);
        end
        RST = 1'b1; SENSOR = 1'b0;
        step(12); chk("held_through_reset", 32'(ESTADO), 0);
        Button = 1'b0; step(2*DB + 4); chk("idle_after_release", 32'(ESTADO), 0);

        Button = 1'b1; step(P); chk("arm_latency_before", 32'(ESTADO), 0);
        step(1); chk("arm_latency_at", 32'(ESTADO), 1); chk("arm_luz", 32'(LUZ), 1);
        Button = 1'b0;
        step(ARM - 1); chk("arming_last", 32'(ESTADO), 1); chk("arming_luz_last", 32'(LUZ), 1);
        step(1); chk("armed", 32'(ESTADO), 2); chk("armed_luz", 32'(LUZ), 0);

        SENSOR = 1'b1; step(2); chk("trig_before", 32'(ESTADO), 2);
        step(1); chk("alarm", 32'(ESTADO), 3);
        SENSOR = 1'b0;
        pat = '0; pat[11] = LUZ;
        for (int i = 10; i >= 0; i--) begin step(1); pat[i] = LUZ; end
        chk("blink_pattern", 32'(pat), 32'hF0F);

        Button = 1'b1; step(P); chk("disarm_before", 32'(ESTADO), 3);
        step(1); chk("disarm", 32'(ESTADO), 0); chk("disarm_luz", 32'(LUZ), 0);
        Button = 1'b0; step(2); SENSOR = 1'b1; step(1); SENSOR = 1'b0;
        step(5); chk("sensor_in_idle", 32'(ESTADO), 0);
        step(2*DB + 4);

        Button = 1'b1; step(DB); Button = 1'b0; step(DB + 2);
        chk("cancel_arming", 32'(ESTADO), 1);
        Button = 1'b1; seen = 0;
        for (int i = 0; i < 16; i++) begin step(1); if (ESTADO == 2'd2) seen = 1; end
        chk("cancel_no_armed", seen, 0); chk("cancel_idle", 32'(ESTADO), 0);
        Button = 1'b0; step(2*DB + 4);

        Button = 1'b1; step(P + 1); Button = 1'b0; chk("arm2", 32'(ESTADO), 1);
        step(ARM + 2*DB + 2); chk("armed2", 32'(ESTADO), 2);
        Button = 1'b1; step(P - 2); SENSOR = 1'b1; step(1); SENSOR = 1'b0;
        step(1); chk("simul_before", 32'(ESTADO), 2);
        step(1); chk("simul_idle", 32'(ESTADO), 0);
        step(4); chk("simul_stays_idle", 32'(ESTADO), 0);
        Button = 1'b0; step(2*DB + 4);

        last = ESTADO; chg = 0;
        for (int i = 0; i < 12; i++) begin
            Button = (i >= 4) || (i % 2 == 0);
            step(1);
            if (ESTADO != last) chg++;
            last = ESTADO;
        end
        chk("bounce_changes", chg, DEB_ON ? 1 : 3); chk("bounce_arming", 32'(ESTADO), 1);

        RST = 1'b0; step(1); chk("abort_reset", 32'(ESTADO), 0); chk("abort_luz", 32'(LUZ), 0);
        RST = 1'b1; step(10); chk("abort_held", 32'(ESTADO), 0);
        Button = 1'b0; step(2*DB + 4);
        Button = 1'b1; step(P + 1); chk("repress_after_reset", 32'(ESTADO), 1);
        Button = 1'b0; step(2*DB + 4);

        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (hold == 0) begin
                Button = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 20);
            end else begin
                hold--;
            end
            SENSOR = ($urandom_range(0, 7) == 0);
            RST = ($urandom_range(0, 299) != 0);
        end
        RST = 1'b1; Button = 1'b0; SENSOR = 1'b0;
        step(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
